quadrature_generator: RTL and testbench



---
 rtl/quadrature_generator.sv | 194 +++++++++++++++++++
 tb/tb_quadrature_generator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_generator.sv
// quadrature_generator
//   Emulates a mechanical rotary encoder: every clockwise or counter-clockwise
//   step request is played out as one full 4-phase Gray-code detent cycle on
//   the A/B pins, starting and ending at A=1, B=1. Requests are queued in a
//   signed saturating counter (positive = cw) and played out one step at a
//   time in the direction of the net queue.
//
//   Optional feature macro: QGEN_BOUNCE_EN. When defined, the channel that
//   changes at each phase change toggles every clock for BOUNCE_CYCLES clocks
//   before settling. When undefined, no bounce logic is built.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-low reset
//   en         allow a new step to start (a running step always completes)
//   step_cw    1-clock request for one clockwise step
//   step_ccw   1-clock request for one counter-clockwise step
//   clr_ovf    synchronous clear of overflow
//   a, b       registered quadrature channels
//   busy       high while a step is being played out
//   pending    signed net queued steps, positive = cw
//   overflow   sticky: a request was dropped by saturation
//   step_done  1-clock pulse when a step completes
module quadrature_generator #(
  parameter int PHASE_CYCLES  = 60000,
  parameter int CNT_W         = 8,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    step_cw,
  input  logic                    step_ccw,
  input  logic                    clr_ovf,
  output logic                    a,
  output logic                    b,
  output logic                    busy,
  output logic signed [CNT_W-1:0] pending,
  output logic                    overflow,
  output logic                    step_done
);

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4} state_t;

  localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PHASE_CYCLES - 1);
  // Two guard bits so pending +/- start +/- request never wraps before the
  // saturation compare.
  localparam int PW = CNT_W + 2;
  localparam logic signed [PW-1:0] P_MAX = PW'((1 << (CNT_W - 1)) - 1);
  localparam logic signed [PW-1:0] P_MIN = -P_MAX;

  if (PHASE_CYCLES < 1 || CNT_W < 2 || BOUNCE_CYCLES < 0) begin : g_bad_params
    $error("quadrature_generator: illegal parameter value");
  end

  state_t                  state, state_nx;
  logic [TW-1:0]           timer;
  logic                    phase_end;
  logic                    dir_cw, dir_nx;
  logic                    start_cw, start_ccw;
  logic signed [PW-1:0]    sum;
  logic signed [CNT_W-1:0] pending_nx;
  logic                    sat;
  logic                    a_nx, b_nx;

  assign phase_end = (timer == T_LAST);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx  = state;
    dir_nx    = dir_cw;
    start_cw  = 1'b0;
    start_ccw = 1'b0;
    unique case (state)
      IDLE: if (en && pending != '0) begin
        state_nx  = PH1;
        dir_nx    = !pending[CNT_W-1];
        start_cw  = !pending[CNT_W-1];
        start_ccw = pending[CNT_W-1];
      end
      PH1:     if (phase_end) state_nx = PH2;
      PH2:     if (phase_end) state_nx = PH3;
      PH3:     if (phase_end) state_nx = PH4;
      PH4:     if (phase_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pin pattern for the state being entered, so a/b change on the same edge
  // as the state. Clockwise drops A while B=1; ccw drops A while B=0.
  always_comb begin
    {a_nx, b_nx} = 2'b11;
    unique case (state_nx)
      PH1:     {a_nx, b_nx} = dir_nx ? 2'b01 : 2'b10;
      PH2:     {a_nx, b_nx} = 2'b00;
      PH3:     {a_nx, b_nx} = dir_nx ? 2'b10 : 2'b01;
      default: {a_nx, b_nx} = 2'b11;
    endcase
  end

  // Queue update: a started step leaves the queue, requests join it.
  always_comb begin
    sum = PW'(pending) + PW'(step_cw) + PW'(start_ccw)
        - PW'(step_ccw) - PW'(start_cw);
    sat        = 1'b0;
    pending_nx = sum[CNT_W-1:0];
    if (sum > P_MAX) begin
      sat        = 1'b1;
      pending_nx = P_MAX[CNT_W-1:0];
    end else if (sum < P_MIN) begin
      sat        = 1'b1;
      pending_nx = P_MIN[CNT_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      dir_cw    <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
      step_done <= 1'b0;
    end else begin
      state     <= state_nx;
      dir_cw    <= dir_nx;
      busy      <= (state_nx != IDLE);
      step_done <= (state != IDLE) && (state_nx == IDLE);
      if (state_nx != state || state == IDLE) timer <= '0;
      else                                    timer <= timer + 1'b1;
      pending   <= pending_nx;
      // A drop in the same cycle as a clear keeps the flag set.
      if (sat)          overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef QGEN_BOUNCE_EN
  if (BOUNCE_CYCLES < 1 || BOUNCE_CYCLES >= PHASE_CYCLES) begin : g_bad_bounce
    $error("quadrature_generator: need 0 < BOUNCE_CYCLES < PHASE_CYCLES");
  end

  localparam int BW = $clog2(BOUNCE_CYCLES + 1);

  logic [BW-1:0] bounce_cnt;
  logic          bounce_on_a;
  logic          tgt_a, tgt_b;

  // tgt_* hold the settled pattern; a change of target is a phase change
  // that moves exactly one channel, which then chatters before settling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a           <= 1'b1;
      b           <= 1'b1;
      tgt_a       <= 1'b1;
      tgt_b       <= 1'b1;
      bounce_cnt  <= '0;
      bounce_on_a <= 1'b0;
    end else begin
      tgt_a <= a_nx;
      tgt_b <= b_nx;
      if (a_nx != tgt_a || b_nx != tgt_b) begin
        a           <= a_nx;
        b           <= b_nx;
        bounce_cnt  <= BW'(BOUNCE_CYCLES - 1);
        bounce_on_a <= (a_nx != tgt_a);
      end else if (bounce_cnt != '0) begin
        if (bounce_on_a) a <= ~a;
        else             b <= ~b;
        bounce_cnt <= bounce_cnt - 1'b1;
      end else begin
        a <= tgt_a;
        b <= tgt_b;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a <= 1'b1;
      b <= 1'b1;
    end else begin
      a <= a_nx;
      b <= b_nx;
    end
  end
`endif

endmodule

// File: tb/tb_quadrature_generator.sv
// Self-checking bench for quadrature_generator (PHASE_CYCLES=4, CNT_W=4).
module tb_quadrature_generator;

  localparam int P    = 4;
  localparam int CW   = 4;
  localparam int MAXP = 7;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic step_cw = 1'b0, step_ccw = 1'b0, clr_ovf = 1'b0;
  logic a, b, busy, overflow, step_done;
  logic signed [CW-1:0] pending;

  int n_chk  = 0;
  int n_fail = 0;

  quadrature_generator #(.PHASE_CYCLES(P), .CNT_W(CW), .BOUNCE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .step_cw(step_cw), .step_ccw(step_ccw),
    .clr_ovf(clr_ovf), .a(a), .b(b), .busy(busy), .pending(pending),
    .overflow(overflow), .step_done(step_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Loopback decoder: A falling while B=1 is a cw detent, while B=0 is ccw.
  logic [1:0] prev_ab = 2'b11;
  int dec_cw = 0, dec_ccw = 0, gray_err = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_ab[1] && a === 1'b0) begin
        if (b) dec_cw++;
        else   dec_ccw++;
      end
      if (({a, b} ^ prev_ab) == 2'b11) gray_err++;
    end
    prev_ab = {a, b};
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // {a, b, busy, overflow, step_done, pending}
  function automatic int obs();
    return int'({a, b, busy, overflow, step_done, pending});
  endfunction

  function automatic int exp_v(input bit ea, eb, ebz, eo, ed, input int ep);
    logic [CW-1:0] p;
    p = CW'(ep);
    return int'({ea, eb, ebz, eo, ed, p});
  endfunction

  task automatic cycle(input bit e, c, cc, cl);
    en = e; step_cw = c; step_ccw = cc; clr_ovf = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step_cw = 1'b0; step_ccw = 1'b0; clr_ovf = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_until_idle(input int limit, output int dones, output int timed_out);
    dones = 0;
    timed_out = 1;
    for (int i = 0; i < limit; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (step_done) dones++;
      if (!busy && pending == '0) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  // Table of single-cycle stimulus followed by 'gap' quiet cycles, then a check.
  typedef struct {
    string name;
    bit en, cw, ccw, clr;
    int gap;
    bit a, b, busy, ovf, done;
    int pend;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input string n, input bit e, c, cc, cl, input int g,
                     input bit ea, eb, ebz, eo, ed, input int ep);
    vec_t v;
    v.name = n; v.en = e; v.cw = c; v.ccw = cc; v.clr = cl; v.gap = g;
    v.a = ea; v.b = eb; v.busy = ebz; v.ovf = eo; v.done = ed; v.pend = ep;
    tbl.push_back(v);
  endtask

  // Reference model: a step is a count of elapsed clocks; the pin pattern is
  // looked up from elapsed / P.
  int m_pend, m_el;
  bit m_busy, m_dir, m_ovf, m_done;
  logic [1:0] cw_tab  [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
  logic [1:0] ccw_tab [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

  task automatic model_reset();
    m_pend = 0; m_el = 0; m_busy = 0; m_dir = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic model_step(input bit e, c, cc, cl);
    int st, nx;
    bit s;
    st = 0;
    if (!m_busy && e && m_pend != 0) st = (m_pend > 0) ? 1 : -1;
    nx = m_pend - st + int'(c) - int'(cc);
    s = 0;
    if (nx > MAXP)  begin nx = MAXP;  s = 1; end
    if (nx < -MAXP) begin nx = -MAXP; s = 1; end
    if (s)       m_ovf = 1;
    else if (cl) m_ovf = 0;
    m_done = 0;
    if (m_busy) begin
      m_el++;
      if (m_el == 4 * P) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (st != 0) begin
      m_busy = 1;
      m_el = 0;
      m_dir = (st > 0);
    end
    m_pend = nx;
  endtask

  function automatic int model_exp();
    logic [1:0] ab;
    ab = 2'b11;
    if (m_busy) ab = m_dir ? cw_tab[m_el / P] : ccw_tab[m_el / P];
    return exp_v(ab[1], ab[0], m_busy, m_ovf, m_done, m_pend);
  endfunction

  initial begin
    int dones, tmo, base_cw, base_ccw, bad;
    bit r_en, r_cw, r_ccw, r_clr;

    // Reset state
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset state", obs(), exp_v(1, 1, 0, 0, 0, 0));
    rst = 1'b1;

    //   name          en cw ccw clr gap  a  b busy ovf done pend
    add("cw req",      1, 1, 0, 0, 0,   1, 1, 0, 0, 0,  1);
    add("cw ph1",      1, 0, 0, 0, 0,   0, 1, 1, 0, 0,  0);
    add("cw ph2",      1, 0, 0, 0, 3,   0, 0, 1, 0, 0,  0);
    add("cw ph3",      1, 0, 0, 0, 3,   1, 0, 1, 0, 0,  0);
    add("cw ph4",      1, 0, 0, 0, 3,   1, 1, 1, 0, 0,  0);
    add("cw done",     1, 0, 0, 0, 3,   1, 1, 0, 0, 1,  0);
    add("cw idle",     1, 0, 0, 0, 0,   1, 1, 0, 0, 0,  0);
    add("ccw req",     1, 0, 1, 0, 0,   1, 1, 0, 0, 0, -1);
    add("ccw ph1",     1, 0, 0, 0, 0,   1, 0, 1, 0, 0,  0);
    add("ccw ph2",     1, 0, 0, 0, 3,   0, 0, 1, 0, 0,  0);
    add("ccw ph3",     1, 0, 0, 0, 3,   0, 1, 1, 0, 0,  0);
    add("ccw ph4",     1, 0, 0, 0, 3,   1, 1, 1, 0, 0,  0);
    add("ccw done",    1, 0, 0, 0, 3,   1, 1, 0, 0, 1,  0);
    add("ccw idle",    1, 0, 0, 0, 0,   1, 1, 0, 0, 0,  0);
    add("both req",    1, 1, 1, 0, 0,   1, 1, 0, 0, 0,  0);
    add("both quiet",  1, 0, 0, 0, 5,   1, 1, 0, 0, 0,  0);
    add("en0 req",     0, 1, 0, 0, 0,   1, 1, 0, 0, 0,  1);
    add("en0 hold",    0, 0, 0, 0, 6,   1, 1, 0, 0, 0,  1);
    add("en1 start",   1, 0, 0, 0, 0,   0, 1, 1, 0, 0,  0);
    add("en1 done",    1, 0, 0, 0, 15,  1, 1, 0, 0, 1,  0);

    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].cw, tbl[i].ccw, tbl[i].clr);
      repeat (tbl[i].gap) cycle(tbl[i].en, 1'b0, 1'b0, 1'b0);
      check(tbl[i].name, obs(), exp_v(tbl[i].a, tbl[i].b, tbl[i].busy,
                                      tbl[i].ovf, tbl[i].done, tbl[i].pend));
    end
    check("table dec cw", dec_cw, 2);
    check("table dec ccw", dec_ccw, 1);

    // Saturation with en=0, then drain.
    repeat (7) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("sat edge", obs(), exp_v(1, 1, 0, 0, 0, 7));
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("sat ovf", obs(), exp_v(1, 1, 0, 1, 0, 7));
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("sat set wins", obs(), exp_v(1, 1, 0, 1, 0, 7));
    base_cw = dec_cw; base_ccw = dec_ccw;
    run_until_idle(7 * 4 * P + 40, dones, tmo);
    check("drain timeout", tmo, 0);
    check("drain dones", dones, 7);
    check("drain dec cw", dec_cw - base_cw, 7);
    check("drain dec ccw", dec_ccw - base_ccw, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("clr ovf", obs(), exp_v(1, 1, 0, 0, 0, 0));

    // Reversal requested mid-PH2 of a cw step.
    base_cw = dec_cw; base_ccw = dec_ccw;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("rev ph2", obs(), exp_v(0, 0, 1, 0, 0, 0));
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("rev pend", obs(), exp_v(0, 0, 1, 0, 0, -3));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("rev ph3 kept cw", obs(), exp_v(1, 0, 1, 0, 0, -3));
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("rev cw done", obs(), exp_v(1, 1, 0, 0, 1, -3));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("rev ccw ph1", obs(), exp_v(1, 0, 1, 0, 0, -2));
    run_until_idle(3 * 4 * P + 40, dones, tmo);
    check("rev timeout", tmo, 0);
    check("rev dones", dones, 3);
    check("rev dec cw", dec_cw - base_cw, 1);
    check("rev dec ccw", dec_ccw - base_ccw, 3);

    // Asynchronous reset during PH3 with a step still queued.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("abort ph3", obs(), exp_v(1, 0, 1, 0, 0, 1));
    #2 rst = 1'b0;
    #1;
    check("abort async", obs(), exp_v(1, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (step_done || busy || !a || !b) bad++;
    end
    check("abort quiet", bad, 0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    r_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) r_en = ~r_en;
      r_cw  = ($urandom_range(0, 5) == 0);
      r_ccw = ($urandom_range(0, 9) == 0);
      r_clr = ($urandom_range(0, 29) == 0);
      cycle(r_en, r_cw, r_ccw, r_clr);
      model_step(r_en, r_cw, r_ccw, r_clr);
      check($sformatf("rand cyc %0d", i), obs(), model_exp());
    end

    check("gray code", gray_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
